// File: rtl/lut_sweep_pkg.sv
// Shared types and constants for the LUT sweep unit.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Mode selects how the term mask is read: minterm list or maxterm list.
  localparam logic MODE_SOP = 1'b0;
  localparam logic MODE_POS = 1'b1;

endpackage

// File: rtl/lut_term_lookup.sv
// Combinational term lookup: F(idx) = mask[idx] ^ mode.
module lut_term_lookup #(
  parameter int N = 4
) (
  input  logic [2**N-1:0] mask,
  input  logic            mode,
  input  logic [N-1:0]    idx,
  output logic            f
);

  // A set bit is a true row in SoP and a false row in PoS.
  assign f = mask[idx] ^ mode;

endmodule

// File: rtl/lut_sweep_unit.sv
// Loadable N-input function generator with point evaluation and a
// truth-table sweep engine streaming rows over valid/ready.
module lut_sweep_unit
  import lut_sweep_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [2**N-1:0] mask_in,
  input  logic            mode_in,
  input  logic [N-1:0]    eval_in,
  output logic            eval_out,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_idx,
  output logic            out_val,
  output logic            done,
  output logic [N:0]      ones_count
);

  localparam int ROWS = 2**N;

  state_t          state;
  logic [ROWS-1:0] mask;
  logic            mode;
  logic [N:0]      acc;
  logic [N-1:0]    sweep_idx;
  logic            f_eval;
  logic            f_sweep;

  // Sweep lookup always points at the row that will be presented next:
  // row 0 when launching from IDLE, otherwise the successor of out_idx.
  assign sweep_idx = (state == ST_SWEEP) ? out_idx + 1'b1 : '0;

  lut_term_lookup #(.N(N)) u_eval_lookup (
    .mask (mask),
    .mode (mode),
    .idx  (eval_in),
    .f    (f_eval)
  );

  lut_term_lookup #(.N(N)) u_sweep_lookup (
    .mask (mask),
    .mode (mode),
    .idx  (sweep_idx),
    .f    (f_sweep)
  );

  // Table registers, point-eval register and the sweep FSM with its counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mask       <= '0;
      mode       <= MODE_SOP;
      eval_out   <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_val    <= 1'b0;
      done       <= 1'b0;
      acc        <= '0;
      ones_count <= '0;
    end else begin
      eval_out <= f_eval;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          // load takes priority so a table update never races a sweep launch
          if (load) begin
            mask <= mask_in;
            mode <= mode_in;
          end else if (start) begin
            state     <= ST_SWEEP;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_val   <= f_sweep;
            acc       <= '0;
          end
        end
        ST_SWEEP: begin
          if (out_valid && out_ready) begin
            if (out_idx == '1) begin
              out_valid  <= 1'b0;
              ones_count <= acc + {{N{1'b0}}, out_val};
              done       <= 1'b1;
              state      <= ST_DONE;
            end else begin
              acc     <= acc + {{N{1'b0}}, out_val};
              out_idx <= out_idx + 1'b1;
              out_val <= f_sweep;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_sweep_unit.sv
// Directed bench for lut_sweep_unit: N=4 main instance plus an N=3 instance.
module tb_lut_sweep_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // N=4 instance signals
  logic        load = 1'b0;
  logic [15:0] mask_in = '0;
  logic        mode_in = 1'b0;
  logic [3:0]  eval_in = '0;
  logic        eval_out;
  logic        start = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_idx;
  logic        out_val;
  logic        done;
  logic [4:0]  ones_count;

  // N=3 instance signals
  logic        c_load = 1'b0;
  logic [7:0]  c_mask_in = '0;
  logic        c_mode_in = 1'b0;
  logic [2:0]  c_eval_in = '0;
  logic        c_eval_out;
  logic        c_start = 1'b0;
  logic        c_busy;
  logic        c_out_valid;
  logic        c_out_ready = 1'b1;
  logic [2:0]  c_out_idx;
  logic        c_out_val;
  logic        c_done;
  logic [3:0]  c_ones_count;

  int tests = 0;
  int fails = 0;

  lut_sweep_unit #(.N(4)) dut (
    .clk(clk), .rst(rst), .load(load), .mask_in(mask_in), .mode_in(mode_in),
    .eval_in(eval_in), .eval_out(eval_out), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_val(out_val), .done(done), .ones_count(ones_count)
  );

  lut_sweep_unit #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .load(c_load), .mask_in(c_mask_in), .mode_in(c_mode_in),
    .eval_in(c_eval_in), .eval_out(c_eval_out), .start(c_start), .busy(c_busy),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_idx(c_out_idx),
    .out_val(c_out_val), .done(c_done), .ones_count(c_ones_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Run a full N=4 sweep; optional backpressure at row 5 and ignored
  // load/start at row 3.
  task automatic sweep4(input logic [15:0] expv, input int exp_ones,
                        input bit bp, input bit ign);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sweep_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("row_valid", 32'(out_valid), 32'd1);
      check("row_idx", 32'(out_idx), 32'(i));
      check("row_val", 32'(out_val), 32'(expv[i]));
      if (bp && i == 5) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_idx", 32'(out_idx), 32'd5);
          check("bp_val", 32'(out_val), 32'(expv[5]));
        end
        out_ready = 1'b1;
      end
      if (ign && i == 3) begin
        load = 1'b1; mask_in = 16'hFFFF; mode_in = 1'b0; start = 1'b1;
      end
      if (i < 15) check("no_early_done", 32'(done), 32'd0);
      tick();
      load = 1'b0; start = 1'b0;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ones_count", 32'(ones_count), 32'(exp_ones));
    check("busy_in_done", 32'(busy), 32'd1);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("ones_hold", 32'(ones_count), 32'(exp_ones));
  endtask

  initial begin
    // Reset
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    eval_in = 4'hF;
    tick();
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_val", 32'(out_val), 32'd0);
    check("rst_ones", 32'(ones_count), 32'd0);
    check("rst_f_zero", 32'(eval_out), 32'd0);

    // Load PoS table; eval in the load cycle still sees the old (all-zero) table
    load = 1'b1; mask_in = 16'h5157; mode_in = 1'b1; eval_in = 4'b1010;
    tick();
    load = 1'b0;
    check("eval_old_mask", 32'(eval_out), 32'd0);
    tick();
    check("eval_1010", 32'(eval_out), 32'd1);
    eval_in = 4'b0110;
    tick();
    check("eval_0110", 32'(eval_out), 32'd0);
    eval_in = 4'b0000;
    tick();
    check("eval_0000", 32'(eval_out), 32'd0);
    eval_in = 4'b1111;
    tick();
    check("eval_1111", 32'(eval_out), 32'd1);

    // Full PoS sweep with backpressure and ignored commands.
    // Expected rows 0..15: 0,0,0,1,0,1,0,1,0,1,1,1,0,1,0,1 -> 16'hAEA8
    sweep4(16'hAEA8, 8, 1'b1, 1'b1);
    eval_in = 4'b0000;
    tick();
    check("mask_kept", 32'(eval_out), 32'd0);

    // load + start together in IDLE: load wins, no sweep
    load = 1'b1; start = 1'b1; mask_in = 16'h0001; mode_in = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    check("ls_no_busy", 32'(busy), 32'd0);
    check("ls_no_valid", 32'(out_valid), 32'd0);
    tick();
    check("ls_still_idle", 32'(busy), 32'd0);
    check("ls_new_mask", 32'(eval_out), 32'd1);
    check("ls_ones_hold", 32'(ones_count), 32'd8);

    // SoP sweep: only row 0 true
    sweep4(16'h0001, 1, 1'b0, 1'b0);

    // Async reset at row 7
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("mid_idx7", 32'(out_idx), 32'd7);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ones", 32'(ones_count), 32'd0);
    check("arst_idx", 32'(out_idx), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("arst_no_done", 32'(done), 32'd0);
    end

    // N=3 instance: all-true SoP table
    c_load = 1'b1; c_mask_in = 8'hFF; c_mode_in = 1'b0;
    tick();
    c_load = 1'b0;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("n3_valid", 32'(c_out_valid), 32'd1);
      check("n3_idx", 32'(c_out_idx), 32'(i));
      check("n3_val", 32'(c_out_val), 32'd1);
      tick();
    end
    check("n3_done", 32'(c_done), 32'd1);
    check("n3_ones", 32'(c_ones_count), 32'd8);
    tick();
    check("n3_idle", 32'(c_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lut_sweep_unit.md
Name: lut_sweep_unit

Overview:
- Parametrised successor to the fixed 4-input SoP/PoS expression blocks.
- Holds a loadable 2^N-bit term mask. The mask is interpreted as a minterm list (SoP) or a maxterm list (PoS), selected by mode.
- Provides a registered single-point evaluation path.
- Provides a sweep engine that streams the full truth table over a valid/ready handshake and counts true rows.
- Used as the function generator and self-checking truth-table source in the guide test benches.

Parameters:
- N, 4, number of function inputs (2..8)
- ROWS, 2**N, derived localparam, truth-table rows; not overridable

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- load  in  1  pulse; capture mask_in and mode_in
- mask_in  in  ROWS  term mask; bit i = term i
- mode_in  in  1  0 = SoP (bit set → F=1), 1 = PoS (bit set → F=0)
- eval_in  in  N  input vector for point evaluation, MSB = first variable (X)
- eval_out  out  1  registered F(eval_in)
- start  in  1  pulse; begin truth-table sweep
- busy  out  1  high in SWEEP and DONE
- out_valid  out  1  sweep row available
- out_ready  in  1  consumer accepts row
- out_idx  out  N  row index of current sweep output
- out_val  out  1  F(out_idx)
- done  out  1  one-cycle pulse after last row accepted
- ones_count  out  N+1  number of rows with F=1 in last completed sweep

Behaviour:
- Function rule: F(i) = mask[i] XOR mode. Mask and mode are held in registers.
- Reset values (async, immediate): mask=0, mode=0, eval_out=0, busy=0, out_valid=0, out_idx=0, out_val=0, done=0, ones_count=0, state=IDLE.
- With mask=0 after reset, F is all-zero (SoP).
- Load: when load=1 in IDLE, mask and mode update at the clock edge. load is ignored in SWEEP and DONE, so the table is stable during a sweep.
- Eval path: eval_out <= F(eval_in) every cycle in every state, latency 1 cycle. It uses the mask/mode registered before the edge. If load and eval happen in the same cycle, eval_out reflects the old mask.
- State machine: IDLE, SWEEP, DONE.
- IDLE:
  - start=1 → SWEEP.
  - At that edge: out_idx=0, out_valid=1, out_val=F(0), internal accumulator cleared.
  - If load and start are both 1 in the same cycle, load wins: mask is captured, start is ignored.
- SWEEP:
  - A row transfers on out_valid & out_ready.
  - On transfer the accumulator adds out_val.
  - If out_idx < ROWS-1: out_idx increments and out_val=F(out_idx+1) on the same edge. Throughput is 1 row/cycle with out_ready held high.
  - If out_idx = ROWS-1: out_valid drops, ones_count <= accumulator + out_val, next state DONE.
  - If out_ready=0: out_idx and out_val hold stable, out_valid stays 1 (no retraction).
  - start during SWEEP is ignored.
- DONE: done=1 for exactly one cycle → IDLE. busy deasserts at that IDLE entry.
- ones_count: holds between sweeps and changes only at sweep completion. The width N+1 holds ROWS (all-true function) without overflow.
- Reset mid-sweep: outputs return to reset values immediately. No done pulse is produced, and ones_count is cleared.
- Sweep latency with out_ready=1: start edge → first valid is 1 cycle; last transfer → done is 1 cycle; total ROWS+2 cycles start-to-IDLE.

Decomposition:
- Package lut_sweep_pkg holds:
  - state enum/constants ST_IDLE=2'd0, ST_SWEEP=2'd1, ST_DONE=2'd2
  - mode constants MODE_SOP=1'b0, MODE_POS=1'b1
- One sub-module, lut_term_lookup (parameter N): combinational F = mask[idx] ^ mode.
  - Instantiated twice: eval path and sweep path.
- Top module holds the mask registers, FSM, index counter and accumulator.

Test Plan:
- Reset and PoS eval:
  - Stimulus: rst pulse, then load mask=16'h5157 (maxterms 0,1,2,4,6,8,12,14), mode=1.
  - Response: eval_in=4'b1010 → eval_out=1 next cycle; eval_in=4'b0110 → 0; eval_in=4'b0000 → 0.
- Full PoS sweep:
  - Stimulus: same mask, start, out_ready=1.
  - Response:
    - 16 transfers idx 0..15
    - out_val = 0,0,0,1,0,1,0,1,0,1,1,1,0,1,0,1
    - done pulse one cycle after idx 15
    - ones_count=8
    - busy low on the following cycle
- SoP mode sweep:
  - Stimulus: load mask=16'h0001, mode=0, sweep.
  - Response: only idx 0 has out_val=1; ones_count=1.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles while out_idx=5.
  - Response: out_idx=5, out_val and out_valid stay stable; no skipped or duplicated row; ones_count still 8.
- Ignored commands:
  - Stimulus: load mask=16'hFFFF and start during SWEEP; load+start together in IDLE.
  - Response: sweep continues with the old table. In IDLE the mask is captured and no sweep starts.
- Async reset mid-sweep and N=3 instance:
  - Stimulus: assert rst at idx 7 of a sweep.
  - Response: out_valid, busy and ones_count go to 0 before the next edge, and no done pulse.
  - Stimulus: N=3 instance, mask=8'hFF, mode=0.
  - Response: 8 rows, ones_count=8.
